// File: rtl/tqvp_arb_pkg.sv
// -----------------------------------------------------------------------------
// tqvp_arb_pkg
// Shared types and constants for the two-requester TinyQV peripheral bus
// arbiter: FSM state encoding, transaction width codes, strobe idle value,
// timeout read-data pattern and the read-data width mask helper.
// -----------------------------------------------------------------------------
package tqvp_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      ACK  = 2'd3
   } arb_state_t;

   // Transaction width codes; also the active value driven on the strobes.
   localparam logic [1:0] TXN_BYTE = 2'b00;
   localparam logic [1:0] TXN_HALF = 2'b01;
   localparam logic [1:0] TXN_WORD = 2'b10;
   localparam logic [1:0] TXN_BAD  = 2'b11;

   localparam logic [1:0]  STROBE_IDLE   = 2'b11;
   localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

   // Zero the bytes above the transaction width.
   function automatic logic [31:0] mask_rdata(input logic [1:0]  txn,
                                              input logic [31:0] data);
      case (txn)
         TXN_BYTE: return {24'h0, data[7:0]};
         TXN_HALF: return {16'h0, data[15:0]};
         default:  return data;
      endcase
   endfunction

endpackage

// File: rtl/tqvp_arb_rr2.sv
// -----------------------------------------------------------------------------
// tqvp_arb_rr2
// Two-way round-robin grant. A single pointer bit decides who wins when both
// requesters are active; it is updated only when the caller accepts the grant.
//
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset (pointer favours requester 0)
//   i_req     in   [1:0] request bits
//   i_update  in   grant accepted this cycle; advance the pointer
//   o_grant   out  [1:0] one-hot grant (all zero when no request)
// -----------------------------------------------------------------------------
module tqvp_arb_rr2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_req,
   input  logic       i_update,
   output logic [1:0] o_grant
);

   // 0: requester 0 wins a tie, 1: requester 1 wins a tie.
   logic r_ptr;

   // NOTE: every signal written in always_comb gets a default first, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      o_grant = 2'b00;
      case (i_req)
         2'b01:   o_grant = 2'b01;
         2'b10:   o_grant = 2'b10;
         2'b11:   o_grant = r_ptr ? 2'b10 : 2'b01;
         default: o_grant = 2'b00;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops sample
   // the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= 1'b0;
      end else if (i_update && (|o_grant)) begin
         // Whoever was just served loses the next tie.
         r_ptr <= o_grant[0];
      end
   end

endmodule

// File: rtl/tqvp_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tqvp_bus_arbiter
// Lets two hosts share one TinyQV tqvp_* peripheral. Requests are arbitrated
// round-robin, the winner's command is latched, the peripheral strobes are
// driven (one cycle for writes, until data_ready for reads) and a one-cycle
// ack returns width-masked read data and an error flag.
//
// Optional feature macro: TQVP_ARB_TIMEOUT_EN
//   defined   - reads give up after TIMEOUT_CYCLES waiting cycles with
//               err_o=1 and rdata_o=32'hFFFF_FFFF
//   undefined - reads wait for data_ready indefinitely
//
// Parameters:
//   ADDR_W          peripheral address width
//   TIMEOUT_CYCLES  read-wait limit, 1..255 (timeout build only)
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req_i[1:0]     level requests, held until ack
//   rw_i[1:0]      1=write, 0=read
//   txn_i[1:0]     2-bit width per requester (00 byte, 01 half, 10 word, 11 bad)
//   addr_i[1:0]    address per requester
//   wdata_i[1:0]   write data per requester
//   ack_o[1:0]     one-cycle completion pulse per requester
//   err_o          with ack: illegal width or read timeout
//   rdata_o        with ack: read data (0 for writes / illegal)
//   address        peripheral address
//   data_in        peripheral write data
//   data_write_n   peripheral write strobe (11 idle, else width)
//   data_read_n    peripheral read strobe (11 idle, else width)
//   data_out       peripheral read data
//   data_ready     peripheral read data valid
// -----------------------------------------------------------------------------
module tqvp_bus_arbiter
   import tqvp_arb_pkg::*;
#(
   parameter int ADDR_W         = 6,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [1:0]             req_i,
   input  logic [1:0]             rw_i,
   input  logic [1:0][1:0]        txn_i,
   input  logic [1:0][ADDR_W-1:0] addr_i,
   input  logic [1:0][31:0]       wdata_i,
   output logic [1:0]             ack_o,
   output logic                   err_o,
   output logic [31:0]            rdata_o,
   output logic [ADDR_W-1:0]      address,
   output logic [31:0]            data_in,
   output logic [1:0]             data_write_n,
   output logic [1:0]             data_read_n,
   input  logic [31:0]            data_out,
   input  logic                   data_ready
);

   arb_state_t r_state;
   arb_state_t w_state_next;

   // Arbitration
   logic [1:0] w_grant;
   logic       w_sel;
   logic       w_load;
   logic [1:0] w_sel_txn;
   logic       w_sel_rw;

   // Latched command. The direction is not stored separately: after the
   // grant it is fully encoded by the FSM being in WR or RD.
   logic              r_gnt;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [1:0]        r_txn;

   // Values to present on the next ack
   logic        w_err_next;
   logic [31:0] w_rdata_next;
   logic        w_tmo_hit;

   // Effective command for the next cycle (fresh on grant, else latched)
   logic [1:0] w_txn_eff;
   logic       w_gnt_eff;

   // Registered outputs
   logic [1:0]  r_ack;
   logic        r_err;
   logic [31:0] r_rdata;
   logic [1:0]  r_wr_n;
   logic [1:0]  r_rd_n;

   tqvp_arb_rr2 u_rr2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_req    (req_i),
      .i_update (w_load),
      .o_grant  (w_grant)
   );

   assign w_sel     = w_grant[1];
   assign w_sel_txn = txn_i[w_sel];
   assign w_sel_rw  = rw_i[w_sel];

   assign w_txn_eff = w_load ? w_sel_txn : r_txn;
   assign w_gnt_eff = w_load ? w_sel     : r_gnt;

`ifdef TQVP_ARB_TIMEOUT_EN
   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

   // Counts RD cycles without data_ready; held at zero outside RD so each
   // read starts from zero.
   logic [7:0] r_tmo_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tmo_cnt <= 8'd0;
      end else if (r_state != RD) begin
         r_tmo_cnt <= 8'd0;
      end else if (!data_ready) begin
         r_tmo_cnt <= r_tmo_cnt + 8'd1;
      end
   end

   assign w_tmo_hit = (r_tmo_cnt == TMO_LIMIT);
`else
   // The limit has no consumer when reads wait indefinitely.
   logic w_unused_tmo;
   assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
   assign w_tmo_hit    = 1'b0;
`endif

   // Next-state logic and the ack payload for the transition into ACK.
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_err_next   = 1'b0;
      w_rdata_next = 32'h0;
      case (r_state)
         IDLE: begin
            if (|w_grant) begin
               w_load = 1'b1;
               if (w_sel_txn == TXN_BAD) begin
                  // Illegal width: answer with an error, bus untouched.
                  w_err_next   = 1'b1;
                  w_state_next = ACK;
               end else if (w_sel_rw) begin
                  w_state_next = WR;
               end else begin
                  w_state_next = RD;
               end
            end
         end
         WR: begin
            w_state_next = ACK;
         end
         RD: begin
            // data_ready takes precedence over a timeout in the same cycle.
            if (data_ready) begin
               w_rdata_next = mask_rdata(r_txn, data_out);
               w_state_next = ACK;
            end else if (w_tmo_hit) begin
               w_err_next   = 1'b1;
               w_rdata_next = TIMEOUT_RDATA;
               w_state_next = ACK;
            end
         end
         ACK: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Command latches and registered bus/ack outputs. Strobes are decoded
   // from the next state so they switch on the same edge as the FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gnt   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= 32'h0;
         r_txn   <= TXN_BYTE;
         r_ack   <= 2'b00;
         r_err   <= 1'b0;
         r_rdata <= 32'h0;
         r_wr_n  <= STROBE_IDLE;
         r_rd_n  <= STROBE_IDLE;
      end else begin
         if (w_load) begin
            r_gnt   <= w_sel;
            r_addr  <= addr_i[w_sel];
            r_wdata <= wdata_i[w_sel];
            r_txn   <= w_sel_txn;
         end

         r_wr_n <= (w_state_next == WR) ? w_txn_eff : STROBE_IDLE;
         r_rd_n <= (w_state_next == RD) ? w_txn_eff : STROBE_IDLE;

         r_ack <= 2'b00;
         r_err <= 1'b0;
         if (w_state_next == ACK) begin
            r_ack   <= w_gnt_eff ? 2'b10 : 2'b01;
            r_err   <= w_err_next;
            r_rdata <= w_rdata_next;
         end
      end
   end

   assign ack_o        = r_ack;
   assign err_o        = r_err;
   assign rdata_o      = r_rdata;
   assign address      = r_addr;
   assign data_in      = r_wdata;
   assign data_write_n = r_wr_n;
   assign data_read_n  = r_rd_n;

endmodule

// File: tb/tb_tqvp_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tqvp_bus_arbiter
// Scoreboard bench: stimulus tasks push expected acks and expected bus
// strobes into queues; independent monitors pop and compare whenever the DUT
// presents an ack or drives a strobe. A small peripheral model answers reads
// after a programmable delay.
// -----------------------------------------------------------------------------
module tb_tqvp_bus_arbiter;
   import tqvp_arb_pkg::*;

   localparam int ADDR_W = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic              tb_req   [2];
   logic              tb_rw    [2];
   logic [1:0]        tb_txn   [2];
   logic [ADDR_W-1:0] tb_addr  [2];
   logic [31:0]       tb_wdata [2];

   logic [1:0]             req_i;
   logic [1:0]             rw_i;
   logic [1:0][1:0]        txn_i;
   logic [1:0][ADDR_W-1:0] addr_i;
   logic [1:0][31:0]       wdata_i;
   logic [1:0]             ack_o;
   logic                   err_o;
   logic [31:0]            rdata_o;
   logic [ADDR_W-1:0]      address;
   logic [31:0]            data_in;
   logic [1:0]             data_write_n;
   logic [1:0]             data_read_n;
   logic [31:0]            data_out;
   logic                   data_ready;

   assign req_i   = {tb_req[1], tb_req[0]};
   assign rw_i    = {tb_rw[1], tb_rw[0]};
   assign txn_i   = {tb_txn[1], tb_txn[0]};
   assign addr_i  = {tb_addr[1], tb_addr[0]};
   assign wdata_i = {tb_wdata[1], tb_wdata[0]};

   tqvp_bus_arbiter #(
      .ADDR_W         (ADDR_W),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_i        (req_i),
      .rw_i         (rw_i),
      .txn_i        (txn_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .ack_o        (ack_o),
      .err_o        (err_o),
      .rdata_o      (rdata_o),
      .address      (address),
      .data_in      (data_in),
      .data_write_n (data_write_n),
      .data_read_n  (data_read_n),
      .data_out     (data_out),
      .data_ready   (data_ready)
   );

   always #5 clk = ~clk;

   // Cycle index; updated at each posedge, read away from the edge.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   typedef struct {
      int          idx;
      logic        err;
      logic [31:0] rdata;
      int          cyc;
   } ack_exp_t;

   typedef struct {
      logic              is_wr;
      logic [1:0]        strobe;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
      int                len;
      int                cyc;
   } bus_exp_t;

   ack_exp_t ack_q[$];
   bus_exp_t bus_q[$];

   function automatic logic [1:0] onehot(input int idx);
      return (idx == 1) ? 2'b10 : 2'b01;
   endfunction

   // ---------------- ack monitor ----------------
   initial begin
      ack_exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && ack_o != 2'b00) begin
            if (ack_q.size() == 0) begin
               check("unexpected_ack", 32'(ack_o), 32'h0);
            end else begin
               e = ack_q.pop_front();
               check("ack_bits",  32'(ack_o), 32'(onehot(e.idx)));
               check("ack_err",   32'(err_o), 32'(e.err));
               check("ack_rdata", rdata_o, e.rdata);
               check("ack_cycle", 32'(cyc), 32'(e.cyc));
            end
         end
      end
   end

   // ---------------- bus monitor ----------------
   initial begin
      bus_exp_t          e;
      int                rd_run;
      logic [1:0]        rd_strb;
      logic [ADDR_W-1:0] rd_addr;
      int                rd_start;
      rd_run   = 0;
      rd_strb  = STROBE_IDLE;
      rd_addr  = '0;
      rd_start = 0;
      forever begin
         @(negedge clk);
         if (data_write_n != STROBE_IDLE || data_read_n != STROBE_IDLE)
            check("one_strobe", 32'(data_write_n != STROBE_IDLE && data_read_n != STROBE_IDLE), 32'h0);

         if (data_write_n != STROBE_IDLE) begin
            if (bus_q.size() == 0) begin
               check("unexpected_write", 32'(data_write_n), 32'(STROBE_IDLE));
            end else begin
               e = bus_q.pop_front();
               check("wr_kind",    32'h1, 32'(e.is_wr));
               check("wr_strobe",  32'(data_write_n), 32'(e.strobe));
               check("wr_address", 32'(address), 32'(e.addr));
               check("wr_data",    data_in, e.wdata);
               check("wr_cycle",   32'(cyc), 32'(e.cyc));
            end
         end

         if (data_read_n != STROBE_IDLE) begin
            if (rd_run == 0) begin
               rd_strb  = data_read_n;
               rd_addr  = address;
               rd_start = cyc;
            end else begin
               check("rd_strobe_stable", 32'(data_read_n), 32'(rd_strb));
            end
            rd_run++;
         end else if (rd_run > 0) begin
            if (bus_q.size() == 0) begin
               check("unexpected_read", 32'(rd_run), 32'h0);
            end else begin
               e = bus_q.pop_front();
               check("rd_kind",    32'h0, 32'(e.is_wr));
               check("rd_strobe",  32'(rd_strb), 32'(e.strobe));
               check("rd_address", 32'(rd_addr), 32'(e.addr));
               check("rd_length",  32'(rd_run), 32'(e.len));
               check("rd_cycle",   32'(rd_start), 32'(e.cyc));
            end
            rd_run = 0;
         end
      end
   end

   // ---------------- peripheral model ----------------
   int          rd_delay = 0;
   logic [31:0] rd_word  = 32'h0;

   initial begin
      int wait_cnt;
      wait_cnt   = 0;
      data_ready = 1'b0;
      data_out   = 32'hA5A5_A5A5;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n || data_read_n == STROBE_IDLE) begin
            wait_cnt   = 0;
            data_ready = 1'b0;
            data_out   = 32'hA5A5_A5A5;
         end else begin
            data_ready = (wait_cnt == rd_delay);
            data_out   = data_ready ? rd_word : 32'hA5A5_A5A5;
            wait_cnt++;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int idx, input logic rw, input logic [1:0] txn,
                          input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
      tb_rw[idx]    = rw;
      tb_txn[idx]   = txn;
      tb_addr[idx]  = addr;
      tb_wdata[idx] = wdata;
      tb_req[idx]   = 1'b1;
   endtask

   task automatic wait_ack(input int idx);
      int k;
      for (k = 0; k < 300; k++) begin
         sync();
         if (ack_o[idx]) break;
      end
      n_checks++;
      if (k < 300) n_pass++;
      else $display("FAIL ack_wait: requester %0d saw no ack within 300 cycles", idx);
      tb_req[idx] = 1'b0;
   endtask

   task automatic do_write(input int idx, input logic [1:0] txn,
                           input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
      int n;
      sync();
      n = cyc;
      bus_q.push_back('{is_wr: 1'b1, strobe: txn, addr: addr, wdata: wdata, len: 1, cyc: n + 1});
      ack_q.push_back('{idx: idx, err: 1'b0, rdata: 32'h0, cyc: n + 2});
      set_req(idx, 1'b1, txn, addr, wdata);
      wait_ack(idx);
   endtask

   task automatic do_read(input int idx, input logic [1:0] txn, input logic [ADDR_W-1:0] addr,
                          input int delay, input logic [31:0] word, input logic [31:0] exp_rdata);
      int n;
      sync();
      n        = cyc;
      rd_delay = delay;
      rd_word  = word;
      bus_q.push_back('{is_wr: 1'b0, strobe: txn, addr: addr, wdata: 32'h0, len: delay + 1, cyc: n + 1});
      ack_q.push_back('{idx: idx, err: 1'b0, rdata: exp_rdata, cyc: n + 2 + delay});
      set_req(idx, 1'b0, txn, addr, 32'h0);
      wait_ack(idx);
   endtask

   task automatic pulse_reset();
      sync();
      rst_n = 1'b0;
      repeat (2) sync();
      rst_n = 1'b1;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin
      int n;
      for (int i = 0; i < 2; i++) begin
         tb_req[i]   = 1'b0;
         tb_rw[i]    = 1'b0;
         tb_txn[i]   = TXN_BYTE;
         tb_addr[i]  = '0;
         tb_wdata[i] = 32'h0;
      end

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_ack",     32'(ack_o), 32'h0);
      check("rst_err",     32'(err_o), 32'h0);
      check("rst_rdata",   rdata_o, 32'h0);
      check("rst_address", 32'(address), 32'h0);
      check("rst_data_in", data_in, 32'h0);
      check("rst_wr_n",    32'(data_write_n), 32'h3);
      check("rst_rd_n",    32'(data_read_n), 32'h3);
      sync();
      rst_n = 1'b1;

      // Word write from requester 0; address/data hold while idle afterwards
      do_write(0, TXN_WORD, 6'h05, 32'hCAFE_BABE);
      repeat (2) sync();
      check("idle_address_hold", 32'(address), 32'h05);
      check("idle_data_in_hold", data_in, 32'hCAFE_BABE);

      // Byte read by requester 1, data_ready three cycles late
      do_read(1, TXN_BYTE, 6'h10, 3, 32'h1234_5678, 32'h0000_0078);
      repeat (2) sync();
      check("rdata_hold", rdata_o, 32'h0000_0078);

      // Half and word reads
      do_read(0, TXN_HALF, 6'h21, 0, 32'hA5A5_1234, 32'h0000_1234);
      do_read(1, TXN_WORD, 6'h3F, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

      // Illegal width: ack at N+1, err, rdata cleared, no strobe
      sync();
      n = cyc;
      ack_q.push_back('{idx: 0, err: 1'b1, rdata: 32'h0, cyc: n + 1});
      set_req(0, 1'b1, TXN_BAD, 6'h07, 32'h5555_5555);
      wait_ack(0);

      // Simultaneous reads, four rounds, starting from the reset pointer
      pulse_reset();
      for (int r = 0; r < 4; r++) begin
         sync();
         n        = cyc;
         rd_delay = 0;
         rd_word  = 32'h1000_0000 + 32'(r);
         bus_q.push_back('{is_wr: 1'b0, strobe: TXN_WORD, addr: 6'(8 + r),  wdata: 32'h0, len: 1, cyc: n + 1});
         bus_q.push_back('{is_wr: 1'b0, strobe: TXN_WORD, addr: 6'(24 + r), wdata: 32'h0, len: 1, cyc: n + 4});
         ack_q.push_back('{idx: 0, err: 1'b0, rdata: 32'h1000_0000 + 32'(r), cyc: n + 2});
         ack_q.push_back('{idx: 1, err: 1'b0, rdata: 32'h1000_0000 + 32'(r), cyc: n + 5});
         set_req(0, 1'b0, TXN_WORD, 6'(8 + r), 32'h0);
         set_req(1, 1'b0, TXN_WORD, 6'(24 + r), 32'h0);
         fork
            wait_ack(0);
            wait_ack(1);
         join
      end

`ifdef TQVP_ARB_TIMEOUT_EN
      // Half read never answered: ack 9 cycles after the strobe starts
      sync();
      n        = cyc;
      rd_delay = 255;
      bus_q.push_back('{is_wr: 1'b0, strobe: TXN_HALF, addr: 6'h2A, wdata: 32'h0, len: 9, cyc: n + 1});
      ack_q.push_back('{idx: 0, err: 1'b1, rdata: 32'hFFFF_FFFF, cyc: n + 10});
      set_req(0, 1'b0, TXN_HALF, 6'h2A, 32'h0);
      wait_ack(0);

      // data_ready on the expiry cycle wins
      do_read(0, TXN_HALF, 6'h2A, 8, 32'h8765_4321, 32'h0000_4321);
`endif

      // Reset during a read wait: strobe drops at once, no ack, pointer reset
      sync();
      n        = cyc;
      rd_delay = 255;
      bus_q.push_back('{is_wr: 1'b0, strobe: TXN_BYTE, addr: 6'h33, wdata: 32'h0, len: 3, cyc: n + 1});
      set_req(0, 1'b0, TXN_BYTE, 6'h33, 32'h0);
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_rd_n", 32'(data_read_n), 32'h3);
      check("midrst_ack",  32'(ack_o), 32'h0);
      tb_req[0] = 1'b0;
      repeat (2) sync();
      rst_n = 1'b1;
      repeat (3) sync();

      // Requester 0 was served last before reset; after reset it wins again
      sync();
      n = cyc;
      bus_q.push_back('{is_wr: 1'b1, strobe: TXN_BYTE, addr: 6'h01, wdata: 32'h0000_0011, len: 1, cyc: n + 1});
      bus_q.push_back('{is_wr: 1'b1, strobe: TXN_WORD, addr: 6'h02, wdata: 32'h2222_2222, len: 1, cyc: n + 4});
      ack_q.push_back('{idx: 0, err: 1'b0, rdata: 32'h0, cyc: n + 2});
      ack_q.push_back('{idx: 1, err: 1'b0, rdata: 32'h0, cyc: n + 5});
      set_req(0, 1'b1, TXN_BYTE, 6'h01, 32'h0000_0011);
      set_req(1, 1'b1, TXN_WORD, 6'h02, 32'h2222_2222);
      fork
         wait_ack(0);
         wait_ack(1);
      join

      repeat (5) sync();
      check("ack_queue_drained", 32'(ack_q.size()), 32'h0);
      check("bus_queue_drained", 32'(bus_q.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
